uart_rx_16x: RTL
================

// Module: uart_rx_16x
// PURPOSE
//  Asynchronous serial receiver, 8N1, LSB first, 16x oversampled off the shared
//  baudclk16 tick. Feeds the UART command bridge: holds one received byte with a
//  level 'ready' flag until the bridge pulses 'read'. Rejects false starts,
//  majority-votes each bit, and flags framing errors and overruns.
// PARAMETERS
//  SYNC_STAGES  2   flops in the rx input synchronizer (>=2)
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-high reset
//  baudclk16  in   1  one-clk-wide tick at 16x baud rate
//  rx         in   1  raw serial input (async, idle high)
//  data       out  8  last good received byte
//  ready      out  1  level; data valid and unread
//  read       in   1  consume strobe; clears ready (may be held = ready)
//  frame_err  out  1  one-clk pulse; stop bit sampled low
//  overrun    out  1  one-clk pulse; new byte overwrote an unread byte
// BEHAVIOUR
//  One clock, clk; reset is synchronous and active-high.
//  Reset: synchronizer flops <= 1; state IDLE; cnt, bit index 0;
//   data 0; ready 0; frame_err 0; overrun 0.
//  All sampling uses rx_s, the SYNC_STAGES-delayed copy of rx. State changes
//   only on clocks with baudclk16=1 (a "tick"), except the read/ready logic.
//  cnt[3:0] counts ticks within a bit, 0..15. Samples are taken at cnt=7,8,9;
//   bit value = majority of the 3 samples.
//  States:
//   IDLE : tick & rx_s=0 -> START, cnt<=0.
//   START: cnt++ per tick; at cnt=9: majority=1 -> IDLE (false start, no flags);
//          else continue; at cnt=15 -> DATA, cnt<=0, bit index 0.
//   DATA : majority at cnt=9 shifted into shift reg MSB (LSB first on wire);
//          at cnt=15: bit index=7 -> STOP, else bit index++; cnt<=0.
//   STOP : at cnt=9: majority=1 -> data<=shift reg, ready<=1, -> IDLE
//          (early return, so resync on next falling edge);
//          majority=0 -> frame_err pulse, data/ready untouched, -> BREAK.
//   BREAK: stay until a tick with rx_s=1 -> IDLE (no lock-up on line held low).
//  Latency: ready rises the clk after the STOP cnt=9 tick.
//  ready: set on load; cleared on clk after read=1 when no load that clk.
//   load and read same clk -> ready stays 1, data = new byte, no overrun.
//   load while ready=1 and read=0 -> data overwritten, overrun pulse 1 clk.
//  read while ready=0: no effect. Pulses never coincide with reset.
//  Reset mid-frame: frame abandoned, no flags; next start bit received normally.
//  baudclk16 period is arbitrary (>=2 clks); behaviour is counted in ticks only.
// TESTING
//  Send 0x6D, 16 ticks/bit, read tied to 0 -> data=0x6D, ready=1 held, no flags.
//  rx low for 4 ticks then high -> no ready, no frame_err, state back to IDLE.
//  Send 0xA5 with stop bit low, then line high -> frame_err 1 pulse, ready=0,
//   then 0x3C sent -> data=0x3C, ready=1.
//  Send 0x11 then 0x22, no read -> overrun 1 pulse at second load, data=0x22.
//  read=ready tied, bytes 0x78,0x72 back-to-back -> each seen ready 1 clk, no
//   overrun; read asserted exactly on second load clk -> ready stays 1.
//  Reset asserted mid-DATA of 0xFF, then 0x5A sent -> data=0x5A, no flags;
//   single-tick glitch per bit at cnt=8 -> byte still correct (majority vote).

Source files
------------

// File: rtl/uart_rx_16x_if.sv
// Receiver-to-bridge handshake: held byte, ready level, consume strobe and error pulses.
interface uart_rx_16x_if;
  logic [7:0] data;
  logic       ready;
  logic       read;
  logic       frame_err;
  logic       overrun;

  modport master (output data, ready, frame_err, overrun, input read);
  modport slave  (input data, ready, frame_err, overrun, output read);
endinterface

// File: rtl/uart_rx_16x.sv
// 8N1 UART receiver, 16x oversampled on baudclk16 ticks, 3-sample majority vote per bit.
module uart_rx_16x #(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             baudclk16,
  input  logic             rx,
  uart_rx_16x_if.master    bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [3:0]             cnt;
  logic [2:0]             bit_idx;
  logic                   s7, s8, maj;
  logic [7:0]             shreg;
  logic [7:0]             data_q;
  logic                   ready_q, fe_q, ovr_q;
  logic                   load, fe_hit, shift_en;

  assign rx_s = sync_q[SYNC_STAGES-1];
  // samples 7 and 8 are held; the third is the live value on the cnt=9 tick
  assign maj  = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      state  <= IDLE;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      state  <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (baudclk16) begin
      case (state)
        IDLE:  if (!rx_s) state_nx = START;
        START: if (cnt == 4'd9 && maj) state_nx = IDLE;
               else if (cnt == 4'd15) state_nx = DATA;
        DATA:  if (cnt == 4'd15 && bit_idx == 3'd7) state_nx = STOP;
        STOP:  if (cnt == 4'd9) state_nx = maj ? IDLE : BRK;
        BRK:   if (rx_s) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    load     = 1'b0;
    fe_hit   = 1'b0;
    shift_en = 1'b0;
    if (baudclk16 && cnt == 4'd9) begin
      load     = (state == STOP) &&  maj;
      fe_hit   = (state == STOP) && !maj;
      shift_en = (state == DATA);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      s7      <= 1'b1;
      s8      <= 1'b1;
      shreg   <= '0;
    end else if (baudclk16) begin
      // cnt is parked at 0 while waiting, so START always begins counting from 0
      cnt <= (state == IDLE || state == BRK) ? 4'd0 : cnt + 4'd1;
      if (state == START) bit_idx <= '0;
      else if (state == DATA && cnt == 4'd15) bit_idx <= bit_idx + 3'd1;
      if (cnt == 4'd7) s7 <= rx_s;
      if (cnt == 4'd8) s8 <= rx_s;
      if (shift_en) shreg <= {maj, shreg[7:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      ready_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      fe_q  <= fe_hit;
      ovr_q <= load && ready_q && !bus.read;
      if (load) begin
        data_q  <= shreg;
        ready_q <= 1'b1;
      end else if (bus.read) begin
        ready_q <= 1'b0;
      end
    end
  end

  assign bus.data      = data_q;
  assign bus.ready     = ready_q;
  assign bus.frame_err = fe_q;
  assign bus.overrun   = ovr_q;

endmodule
